// File: rtl/arbitro_mux.sv
`default_nettype none
// ============================================================================
//  Module   : arbitro_mux
//  Purpose  : Two-source valid/ready arbiter and sequencer for the shared
//             2:1 datapath multiplexer. Grants the path to entrada1 or
//             entrada2 (round-robin by default), locks the grant until the
//             packet's last beat or until MAX_RAFAGA beats have been taken,
//             drives the mux select and registers the chosen beat into a
//             single output stage.
//  Ports    : clk, rst_n (async, active-low)
//             valid1/dato1/last1 -> ready1   : entrada1 beat interface
//             valid2/dato2/last2 -> ready2   : entrada2 beat interface
//             mux_sel                        : 1 = entrada1, 0 = entrada2
//             salida_valid/dato/last <- salida_ready : output beat interface
//  Config   : `define ARBITRO_MUX_PRIORIDAD_FIJA_EN -> entrada1 always wins
//             simultaneous requests in LIBRE (no priority pointer).
//             Undefined (default) -> round-robin priority pointer.
//  Revision : 1.0 - initial release
// ============================================================================
module arbitro_mux #(
  parameter int ANCHO      = 32,
  parameter int MAX_RAFAGA = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid1,
  input  logic [ANCHO-1:0] dato1,
  input  logic             last1,
  output logic             ready1,
  input  logic             valid2,
  input  logic [ANCHO-1:0] dato2,
  input  logic             last2,
  output logic             ready2,
  output logic             mux_sel,
  output logic             salida_valid,
  output logic [ANCHO-1:0] salida_dato,
  output logic             salida_last,
  input  logic             salida_ready
);

  localparam int             CW           = $clog2(MAX_RAFAGA + 1);
  // Counter value seen while the burst-closing beat is being accepted.
  localparam logic [CW-1:0]  c_ultimo_beat = CW'(MAX_RAFAGA - 1);

  typedef enum logic [1:0] {
    LIBRE  = 2'd0,
    SIRVE1 = 2'd1,
    SIRVE2 = 2'd2
  } estado_t;

  estado_t          state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mux_sel_q, mux_sel_d;
  logic             salida_valid_q;
  logic [ANCHO-1:0] salida_dato_q;
  logic             salida_last_q;

  logic             w_salida_libre;
  logic             w_acepta;
  logic             w_limite;
  logic             w_fin;
  logic             w_last_sel;
  logic [ANCHO-1:0] w_dato_sel;
  logic             w_gana1;

  // Output stage can take a beat when empty or draining this cycle.
  // Ready depends only on state and stage occupancy, never on valid.
  assign w_salida_libre = !salida_valid_q || salida_ready;
  assign ready1         = (state_q == SIRVE1) && w_salida_libre;
  assign ready2         = (state_q == SIRVE2) && w_salida_libre;

  assign w_acepta   = (valid1 && ready1) || (valid2 && ready2);
  assign w_dato_sel = (state_q == SIRVE1) ? dato1 : dato2;
  assign w_last_sel = (state_q == SIRVE1) ? last1 : last2;
  assign w_limite   = w_acepta && (cnt_q == c_ultimo_beat);
  assign w_fin      = w_acepta && (w_last_sel || w_limite);

`ifdef ARBITRO_MUX_PRIORIDAD_FIJA_EN
  assign w_gana1 = 1'b1;
`else
  // prio_q = 1 -> entrada1 wins the next tie. Flips to the other source
  // whenever a grant ends, whatever the reason.
  logic prio_q, prio_d;

  always_comb begin
    prio_d = prio_q;
    if (w_fin) begin
      prio_d = (state_q == SIRVE2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b1;
    end else begin
      prio_q <= prio_d;
    end
  end

  assign w_gana1 = prio_q;
`endif

  // Next-state, burst counter and mux select
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mux_sel_d = mux_sel_q;

    case (state_q)
      LIBRE: begin
        if (valid1 && valid2) begin
          state_d = w_gana1 ? SIRVE1 : SIRVE2;
        end else if (valid1) begin
          state_d = SIRVE1;
        end else if (valid2) begin
          state_d = SIRVE2;
        end
      end
      SIRVE1: begin
        // Handover straight to a waiting entrada2 keeps 1 beat/cycle.
        if (w_fin) begin
          state_d = valid2 ? SIRVE2 : LIBRE;
        end
      end
      SIRVE2: begin
        if (w_fin) begin
          state_d = valid1 ? SIRVE1 : LIBRE;
        end
      end
      default: begin
        state_d = LIBRE;
      end
    endcase

    if (w_fin) begin
      cnt_d = '0;
    end else if (w_acepta) begin
      cnt_d = cnt_q + 1'b1;
    end

    // Select is registered from the next state so it is valid during the
    // whole grant and simply holds while idle.
    if (state_d == SIRVE1) begin
      mux_sel_d = 1'b1;
    end else if (state_d == SIRVE2) begin
      mux_sel_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LIBRE;
      cnt_q     <= '0;
      mux_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mux_sel_q <= mux_sel_d;
    end
  end

  // Output register: loads on every accepted beat (acceptance already
  // implies the stage is free), otherwise empties once downstream takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      salida_valid_q <= 1'b0;
      salida_dato_q  <= '0;
      salida_last_q  <= 1'b0;
    end else if (w_acepta) begin
      salida_valid_q <= 1'b1;
      salida_dato_q  <= w_dato_sel;
      salida_last_q  <= w_last_sel || w_limite;
    end else if (salida_ready) begin
      salida_valid_q <= 1'b0;
    end
  end

  assign mux_sel      = mux_sel_q;
  assign salida_valid = salida_valid_q;
  assign salida_dato  = salida_dato_q;
  assign salida_last  = salida_last_q;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arbitro_mux
//  Purpose  : Self-checking bench for arbitro_mux (default round-robin build).
//             Per-cycle directed vectors with hand-computed expectations,
//             plus hand-written reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_arbitro_mux;

  localparam int ANCHO = 32;

  logic             clk;
  logic             rst_n;
  logic             valid1, last1, valid2, last2;
  logic [ANCHO-1:0] dato1, dato2;
  logic             ready1, ready2, mux_sel;
  logic             salida_valid, salida_last, salida_ready;
  logic [ANCHO-1:0] salida_dato;

  int n_checks = 0;
  int n_errors = 0;

  arbitro_mux #(
    .ANCHO      (ANCHO),
    .MAX_RAFAGA (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid1       (valid1),
    .dato1        (dato1),
    .last1        (last1),
    .ready1       (ready1),
    .valid2       (valid2),
    .dato2        (dato2),
    .last2        (last2),
    .ready2       (ready2),
    .mux_sel      (mux_sel),
    .salida_valid (salida_valid),
    .salida_dato  (salida_dato),
    .salida_last  (salida_last),
    .salida_ready (salida_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        v1;
    logic [31:0] d1;
    logic        l1;
    logic        v2;
    logic [31:0] d2;
    logic        l2;
    logic        sr;
    logic        e_r1;
    logic        e_r2;
    logic        e_sel;
    logic        e_sv;
    logic [31:0] e_sd;
    logic        e_sl;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic v1, input logic [31:0] d1, input logic l1,
                              input logic v2, input logic [31:0] d2, input logic l2,
                              input logic sr, input logic e_r1, input logic e_r2,
                              input logic e_sel, input logic e_sv,
                              input logic [31:0] e_sd, input logic e_sl);
    vec_t v;
    v.v1 = v1; v.d1 = d1; v.l1 = l1;
    v.v2 = v2; v.d2 = d2; v.l2 = l2;
    v.sr = sr;
    v.e_r1 = e_r1; v.e_r2 = e_r2; v.e_sel = e_sel;
    v.e_sv = e_sv; v.e_sd = e_sd; v.e_sl = e_sl;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ready1"},       32'(ready1),       32'd0);
    check({tag, "_ready2"},       32'(ready2),       32'd0);
    check({tag, "_mux_sel"},      32'(mux_sel),      32'd0);
    check({tag, "_salida_valid"}, 32'(salida_valid), 32'd0);
    check({tag, "_salida_dato"},  salida_dato,       32'd0);
    check({tag, "_salida_last"},  32'(salida_last),  32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    valid1 = 1'b0; dato1 = '0; last1 = 1'b0;
    valid2 = 1'b0; dato2 = '0; last2 = 1'b0;
    salida_ready = 1'b1;

    // Columns: v1 d1 l1 | v2 d2 l2 | sr || ready1 ready2 mux_sel s_valid s_dato s_last
    // s_dato / s_last are only compared when s_valid is expected high.
    // Idle after reset, then single entrada1 packet A1..A3 (prio -> entrada2)
    add(0, 0,     0, 0, 0,     0, 1,  0, 0, 0, 0, 0,     0); // 0
    add(1, 'hA1,  0, 0, 0,     0, 1,  0, 0, 0, 0, 0,     0); // 1  grant latency
    add(1, 'hA1,  0, 0, 0,     0, 1,  1, 0, 1, 0, 0,     0); // 2
    add(1, 'hA2,  0, 0, 0,     0, 1,  1, 0, 1, 1, 'hA1,  0); // 3
    add(1, 'hA3,  1, 0, 0,     0, 1,  1, 0, 1, 1, 'hA2,  0); // 4
    add(0, 0,     0, 0, 0,     0, 1,  0, 0, 1, 1, 'hA3,  1); // 5  sel holds
    add(0, 0,     0, 0, 0,     0, 1,  0, 0, 1, 0, 0,     0); // 6
    // Tie with prio on entrada2; 2-beat C packet then B handed over with no gap
    add(1, 'hB1,  1, 1, 'hC1,  0, 1,  0, 0, 1, 0, 0,     0); // 7
    add(1, 'hB1,  1, 1, 'hC1,  0, 1,  0, 1, 0, 0, 0,     0); // 8
    add(1, 'hB1,  1, 1, 'hC2,  1, 1,  0, 1, 0, 1, 'hC1,  0); // 9
    add(1, 'hB1,  1, 0, 0,     0, 1,  1, 0, 1, 1, 'hC2,  1); // 10
    add(0, 0,     0, 0, 0,     0, 1,  0, 0, 1, 1, 'hB1,  1); // 11
    // Burst limit: entrada2 streams without last while entrada1 waits
    add(1, 'hE1,  0, 1, 'hD1,  0, 1,  0, 0, 1, 0, 0,     0); // 12
    add(1, 'hE1,  0, 1, 'hD1,  0, 1,  0, 1, 0, 0, 0,     0); // 13
    add(1, 'hE1,  0, 1, 'hD2,  0, 1,  0, 1, 0, 1, 'hD1,  0); // 14
    add(1, 'hE1,  0, 1, 'hD3,  0, 1,  0, 1, 0, 1, 'hD2,  0); // 15
    add(1, 'hE1,  0, 1, 'hD4,  0, 1,  0, 1, 0, 1, 'hD3,  0); // 16
    add(1, 'hE1,  0, 1, 'hD5,  0, 1,  1, 0, 1, 1, 'hD4,  1); // 17 forced cut
    add(1, 'hE2,  1, 1, 'hD5,  0, 1,  1, 0, 1, 1, 'hE1,  0); // 18
    add(0, 0,     0, 1, 'hD5,  0, 1,  0, 1, 0, 1, 'hE2,  1); // 19
    add(0, 0,     0, 1, 'hD6,  1, 1,  0, 1, 0, 1, 'hD5,  0); // 20
    add(0, 0,     0, 0, 0,     0, 1,  0, 0, 0, 1, 'hD6,  1); // 21
    add(0, 0,     0, 0, 0,     0, 1,  0, 0, 0, 0, 0,     0); // 22
    // Backpressure and valid dropping mid-grant on entrada1
    add(1, 'hF1,  0, 0, 0,     0, 1,  0, 0, 0, 0, 0,     0); // 23
    add(1, 'hF1,  0, 0, 0,     0, 1,  1, 0, 1, 0, 0,     0); // 24
    add(1, 'hF2,  0, 0, 0,     0, 0,  0, 0, 1, 1, 'hF1,  0); // 25 stalled
    add(1, 'hF2,  0, 0, 0,     0, 0,  0, 0, 1, 1, 'hF1,  0); // 26
    add(1, 'hF2,  0, 0, 0,     0, 0,  0, 0, 1, 1, 'hF1,  0); // 27
    add(1, 'hF2,  0, 0, 0,     0, 1,  1, 0, 1, 1, 'hF1,  0); // 28 resume
    add(1, 'hF3,  0, 0, 0,     0, 1,  1, 0, 1, 1, 'hF2,  0); // 29
    add(0, 0,     0, 0, 0,     0, 1,  1, 0, 1, 1, 'hF3,  0); // 30 grant kept
    add(1, 'hF4,  1, 0, 0,     0, 1,  1, 0, 1, 0, 0,     0); // 31
    add(0, 0,     0, 0, 0,     0, 0,  0, 0, 1, 1, 'hF4,  1); // 32
    add(0, 0,     0, 0, 0,     0, 1,  0, 0, 1, 1, 'hF4,  1); // 33
    add(0, 0,     0, 0, 0,     0, 1,  0, 0, 1, 0, 0,     0); // 34

    // Power-on reset state
    repeat (2) @(negedge clk);
    #1;
    check_zero_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      valid1 = tbl[i].v1; dato1 = tbl[i].d1; last1 = tbl[i].l1;
      valid2 = tbl[i].v2; dato2 = tbl[i].d2; last2 = tbl[i].l2;
      salida_ready = tbl[i].sr;
      #1;
      check($sformatf("v%0d_ready1", i),       32'(ready1),       32'(tbl[i].e_r1));
      check($sformatf("v%0d_ready2", i),       32'(ready2),       32'(tbl[i].e_r2));
      check($sformatf("v%0d_mux_sel", i),      32'(mux_sel),      32'(tbl[i].e_sel));
      check($sformatf("v%0d_salida_valid", i), 32'(salida_valid), 32'(tbl[i].e_sv));
      if (tbl[i].e_sv) begin
        check($sformatf("v%0d_salida_dato", i), salida_dato,       tbl[i].e_sd);
        check($sformatf("v%0d_salida_last", i), 32'(salida_last),  32'(tbl[i].e_sl));
      end
    end

    // Reset mid-packet: entrada2 on beat 2 of 4; prio is on entrada2 here
    @(negedge clk);
    valid1 = 1'b0; valid2 = 1'b1; dato2 = 32'hB01; last2 = 1'b0; salida_ready = 1'b1;
    @(negedge clk);
    #1;
    check("mid_grant_ready2", 32'(ready2),  32'd1);
    check("mid_grant_sel",    32'(mux_sel), 32'd0);
    @(negedge clk);
    dato2 = 32'hB02;
    #1;
    check("mid_out_valid", 32'(salida_valid), 32'd1);
    check("mid_out_dato",  salida_dato,        32'hB01);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_rst");

    // After release a tie must go to entrada1 (prio back to reset value)
    @(negedge clk);
    rst_n = 1'b1;
    valid1 = 1'b1; dato1 = 32'hC0DE; last1 = 1'b1;
    valid2 = 1'b1; dato2 = 32'hBEEF; last2 = 1'b1;
    #1;
    check("post_rst_ready1", 32'(ready1), 32'd0);
    check("post_rst_ready2", 32'(ready2), 32'd0);
    @(negedge clk);
    #1;
    check("post_rst_tie_ready1", 32'(ready1),  32'd1);
    check("post_rst_tie_ready2", 32'(ready2),  32'd0);
    check("post_rst_tie_sel",    32'(mux_sel), 32'd1);
    @(negedge clk);
    valid1 = 1'b0; valid2 = 1'b0;
    #1;
    check("post_rst_out_valid", 32'(salida_valid), 32'd1);
    check("post_rst_out_dato",  salida_dato,        32'hC0DE);
    check("post_rst_out_last",  32'(salida_last),   32'd1);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
